// File: rtl/ars_sbox8_preimage_if.sv
// Request/candidate bundle for the DES S-box 8 preimage engine.
// master = requester / candidate consumer, slave = engine.
interface ars_sbox8_preimage_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_dout;
    logic [3:0] req_rowmask;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_addr;
    logic [1:0] out_row;
    logic       out_last;
    logic       done;
    logic       chk_err;

    modport master (
        output req_valid, req_dout, req_rowmask, out_ready,
        input  req_ready, out_valid, out_addr, out_row, out_last, done, chk_err
    );

    modport slave (
        input  req_valid, req_dout, req_rowmask, out_ready,
        output req_ready, out_valid, out_addr, out_row, out_last, done, chk_err
    );
endinterface

// File: rtl/ars_sbox8_preimage.sv
// Inverse-lookup engine for DES S-box 8: streams one 6-bit input per selected row that maps to a value.
// Optional forward-model self-check enabled by defining ARS_SBOX8_PREIMAGE_CHECK_EN.
module ars_sbox8_preimage (
    input  logic                        clk,
    input  logic                        rst_n,
    ars_sbox8_preimage_if.slave         bus
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t     r_state;
    logic       r_req_ready;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_done;
    logic [5:0] r_out_addr;
    logic [1:0] r_out_row;
    logic [3:0] r_dout;
    logic [3:0] r_rem;

    // Each row constant holds column 15 in the top nibble, column 0 in the bottom.
    function automatic logic [3:0] sbox8_fwd(input logic [1:0] row, input logic [3:0] col);
        logic [63:0] t;
        case (row)
            2'd0:    t = 64'h7C05E39A1BF6482D;
            2'd1:    t = 64'h29E0B65C473A8DF1;
            2'd2:    t = 64'h853FDA602EC914B7;
            default: t = 64'hB65309CFD8A47E12;
        endcase
        return t[{col, 2'b00} +: 4];
    endfunction

    // Rows are permutations, so exactly one column matches.
    function automatic logic [3:0] sbox8_inv(input logic [1:0] row, input logic [3:0] val);
        logic [3:0] col;
        col = 4'd0;
        for (int c = 0; c < 16; c++)
            if (sbox8_fwd(row, 4'(c)) == val) col = 4'(c);
        return col;
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    logic [3:0] w_src_mask;
    logic [3:0] w_src_dout;
    logic [1:0] w_row;
    logic [3:0] w_rem;
    logic [3:0] w_col;
    logic       w_accept;
    logic       w_out_hs;

    // In IDLE the first candidate comes straight from the request fields.
    assign w_src_mask = (r_state == S_IDLE) ? bus.req_rowmask : r_rem;
    assign w_src_dout = (r_state == S_IDLE) ? bus.req_dout    : r_dout;
    assign w_row      = lowest(w_src_mask);
    assign w_rem      = w_src_mask & ~(4'b0001 << w_row);
    assign w_col      = sbox8_inv(w_row, w_src_dout);
    assign w_accept   = r_req_ready & bus.req_valid;
    assign w_out_hs   = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_addr  <= 6'd0;
            r_out_row   <= 2'd0;
            r_done      <= 1'b0;
            r_dout      <= 4'd0;
            r_rem       <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_dout      <= bus.req_dout;
                        if (bus.req_rowmask == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_EMIT;
                            r_out_valid <= 1'b1;
                            r_out_row   <= w_row;
                            r_out_addr  <= {w_row[1], w_col, w_row[0]};
                            r_out_last  <= (w_rem == 4'd0);
                            r_rem       <= w_rem;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_hs) begin
                        if (r_rem != 4'd0) begin
                            r_out_row  <= w_row;
                            r_out_addr <= {w_row[1], w_col, w_row[0]};
                            r_out_last <= (w_rem == 4'd0);
                            r_rem      <= w_rem;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ARS_SBOX8_PREIMAGE_CHECK_EN
    logic r_chk_err;

    // Map the presented candidate forward again and compare with the latched target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_chk_err <= 1'b0;
        else if (r_out_valid &&
                 (sbox8_fwd({r_out_addr[5], r_out_addr[0]}, r_out_addr[4:1]) != r_dout))
            r_chk_err <= 1'b1;
    end

    assign bus.chk_err = r_chk_err;
`else
    assign bus.chk_err = 1'b0;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_row   = r_out_row;
    assign bus.out_last  = r_out_last;
    assign bus.done      = r_done;
endmodule
